// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory-bus arbiter.
// Physical addresses are {page, 16-bit 8237 address}.
package dma_bus_arbiter_pkg;

    localparam int DEFAULT_PAGE_BITS = 4;
    localparam int NUM_CHANNELS      = 4;
    localparam int PHYS_BITS         = 20;

    localparam logic [1:0] BYTESEL_LO = 2'b01;
    localparam logic [1:0] BYTESEL_HI = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        GRANT,
        XFER,
        XDONE
    } arb_state_t;

    // Odd byte addresses live in the upper lane of the 16-bit word.
    function automatic logic [1:0] lane_sel(input logic odd);
        return odd ? BYTESEL_HI : BYTESEL_LO;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// 16-bit word memory bus shared by the CPU port and the memory port.
// Handshake: the master raises access with addr/wr_en/bytesel/data_out stable and
// holds them until the slave pulses ack for one cycle; read data is valid with ack.
interface dma_bus_arbiter_if;

    logic [18:0] addr;
    logic [15:0] data_out;
    logic        access;
    logic        wr_en;
    logic [1:0]  bytesel;
    logic        ack;
    logic [15:0] data_in;

    modport master (
        output addr, data_out, access, wr_en, bytesel,
        input  ack, data_in
    );

    modport slave (
        input  addr, data_out, access, wr_en, bytesel,
        output ack, data_in
    );

endinterface

// File: rtl/dma_bus_arbiter_page_regs.sv
// Four DMA channel page registers (74LS670 equivalent): synchronous write,
// combinational read selected by the one-hot DACK of the active channel.
module dma_page_registers
    import dma_bus_arbiter_pkg::*;
#(
    parameter int PAGE_BITS = DEFAULT_PAGE_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write,
    input  logic [1:0]           sel,
    input  logic [PAGE_BITS-1:0] data,
    input  logic [3:0]           dack,
    output logic [PAGE_BITS-1:0] page
);

    logic [PAGE_BITS-1:0] regs [NUM_CHANNELS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[sel] <= data;
        end
    end

    // No DACK or a malformed DACK falls back to channel 0 rather than flagging an error.
    always_comb begin
        page = regs[0];
        case (dack)
            4'b0010: page = regs[1];
            4'b0100: page = regs[2];
            4'b1000: page = regs[3];
            default: page = regs[0];
        endcase
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the 16-bit memory bus between the CPU and the KF8237: drains CPU accesses
// before granting hold, then converts MEMR/MEMW strobes into single bus accesses.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int PAGE_BITS = DEFAULT_PAGE_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    dma_bus_arbiter_if.slave         cpu_m,
    dma_bus_arbiter_if.master        mem_m,
    input  logic                     hold_request,
    output logic                     hold_acknowledge,
    input  logic [15:0]              dma_address,
    input  logic [3:0]               dma_acknowledge,
    input  logic                     dma_memory_read,
    input  logic                     dma_memory_write,
    input  logic [7:0]               dma_data_in,
    output logic [7:0]               dma_data_out,
    output logic                     dma_ready,
    input  logic                     page_write,
    input  logic [1:0]               page_sel,
    input  logic [PAGE_BITS-1:0]     page_data,
    output arb_state_t               arb_state
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [PHYS_BITS-1:0] phys_q;
    logic [PHYS_BITS-1:0] phys_next;
    logic                 read_q;
    logic [7:0]           wbyte_q;
    logic [7:0]           rbyte_q;
    logic [PAGE_BITS-1:0] page_cur;
    logic                 strobe;
    logic                 start;
    logic                 dma_owns;

    dma_page_registers #(
        .PAGE_BITS (PAGE_BITS)
    ) u_pages (
        .clock (clock),
        .reset (reset),
        .write (page_write),
        .sel   (page_sel),
        .data  (page_data),
        .dack  (dma_acknowledge),
        .page  (page_cur)
    );

    assign strobe    = dma_memory_read | dma_memory_write;
    assign start     = (state_q == GRANT) && strobe;
    // Page is simply concatenated: an address wrap never carries into the page.
    assign phys_next = PHYS_BITS'({page_cur, dma_address});
    assign dma_owns  = (state_q == GRANT) || (state_q == XFER) || (state_q == XDONE);

    assign cpu_m.data_in = mem_m.data_in;
    assign dma_data_out  = rbyte_q;
    assign arb_state     = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            phys_q  <= '0;
            read_q  <= 1'b0;
            wbyte_q <= '0;
            rbyte_q <= '0;
        end else begin
            state_q <= state_d;
            // Freeze the transfer parameters on entry so mid-transfer page writes wait a turn.
            if (start) begin
                phys_q  <= phys_next;
                read_q  <= dma_memory_read;
                wbyte_q <= dma_data_in;
            end
            if ((state_q == XFER) && mem_m.ack && read_q) begin
                rbyte_q <= phys_q[0] ? mem_m.data_in[15:8] : mem_m.data_in[7:0];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        hold_acknowledge = dma_owns;
        dma_ready        = 1'b1;
        mem_m.addr       = cpu_m.addr;
        mem_m.data_out   = cpu_m.data_out;
        mem_m.access     = cpu_m.access;
        mem_m.wr_en      = cpu_m.wr_en;
        mem_m.bytesel    = cpu_m.bytesel;
        cpu_m.ack        = mem_m.ack;

        if (dma_owns) begin
            mem_m.addr     = phys_q[PHYS_BITS-1:1];
            mem_m.data_out = {wbyte_q, wbyte_q};
            mem_m.access   = 1'b0;
            mem_m.wr_en    = 1'b0;
            mem_m.bytesel  = lane_sel(phys_q[0]);
            cpu_m.ack      = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // An access completing in this very cycle needs no drain.
                if (hold_request) begin
                    state_d = (cpu_m.access && !mem_m.ack) ? DRAIN : GRANT;
                end
            end
            DRAIN: begin
                if (mem_m.ack) state_d = GRANT;
            end
            GRANT: begin
                if (strobe) begin
                    state_d   = XFER;
                    dma_ready = 1'b0;
                end else if (!hold_request) begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                mem_m.access = 1'b1;
                mem_m.wr_en  = !read_q;
                dma_ready    = 1'b0;
                if (mem_m.ack) state_d = XDONE;
            end
            XDONE: begin
                if (!strobe) state_d = GRANT;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a latency-programmable memory responder,
// a scoreboard of expected memory transactions, and timing checks on hold/ready.
module tb_dma_bus_arbiter;
    import dma_bus_arbiter_pkg::*;

    localparam int W = 38;  // {addr[18:0], wr_en, bytesel[1:0], data[15:0]}

    logic       clock;
    logic       reset;
    logic       hold_request;
    logic       hold_acknowledge;
    logic [15:0] dma_address;
    logic [3:0] dma_acknowledge;
    logic       dma_memory_read;
    logic       dma_memory_write;
    logic [7:0] dma_data_in;
    logic [7:0] dma_data_out;
    logic       dma_ready;
    logic       page_write;
    logic [1:0] page_sel;
    logic [3:0] page_data;
    arb_state_t arb_state;

    dma_bus_arbiter_if cpu_m ();
    dma_bus_arbiter_if mem_m ();

    dma_bus_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_m            (cpu_m),
        .mem_m            (mem_m),
        .hold_request     (hold_request),
        .hold_acknowledge (hold_acknowledge),
        .dma_address      (dma_address),
        .dma_acknowledge  (dma_acknowledge),
        .dma_memory_read  (dma_memory_read),
        .dma_memory_write (dma_memory_write),
        .dma_data_in      (dma_data_in),
        .dma_data_out     (dma_data_out),
        .dma_ready        (dma_ready),
        .page_write       (page_write),
        .page_sel         (page_sel),
        .page_data        (page_data),
        .arb_state        (arb_state)
    );

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           mem_lat = 1;
    logic [15:0]  mem_rdata = 16'h0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int cnt;
        cnt = 0;
        mem_m.ack = 1'b0;
        mem_m.data_in = 16'h0;
        forever begin
            @(posedge clock);
            #2;
            mem_m.ack = 1'b0;
            mem_m.data_in = mem_rdata;
            if (mem_m.access) begin
                if (cnt >= mem_lat - 1) begin
                    mem_m.ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (!reset && mem_m.access && mem_m.ack) begin
                act = {mem_m.addr, mem_m.wr_en, mem_m.bytesel,
                       mem_m.wr_en ? mem_m.data_out : 16'h0};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_txn_unexpected: actual=%0h required=none", act);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_txn", act, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cpu_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!cpu_m.ack && cyc < 50);
        if (!cpu_m.ack) begin
            checks++;
            failures++;
            $display("FAIL cpu_ack_timeout: actual=0 required=1");
        end
    endtask

    task automatic cpu_xfer(input logic [18:0] a, input logic w, input logic [1:0] bs,
                            input logic [15:0] d, output int cyc, output logic [15:0] rd);
        exp_q.push_back({a, w, bs, w ? d : 16'h0});
        cpu_m.addr = a;
        cpu_m.wr_en = w;
        cpu_m.bytesel = bs;
        cpu_m.data_out = d;
        cpu_m.access = 1'b1;
        wait_cpu_ack(cyc);
        rd = cpu_m.data_in;
        tick();
        cpu_m.access = 1'b0;
    endtask

    task automatic page_wr(input logic [1:0] s, input logic [3:0] v);
        page_sel = s;
        page_data = v;
        page_write = 1'b1;
        tick();
        page_write = 1'b0;
    endtask

    // Called at posedge+1 with the arbiter in GRANT; leaves it back in GRANT.
    task automatic dma_xfer(input string name, input logic [3:0] dack, input logic [15:0] a,
                            input logic rd, input logic wr, input logic [7:0] d,
                            input logic [W-1:0] exp_txn, input int hold_after,
                            input logic pw, input logic [1:0] pw_sel, input logic [3:0] pw_val);
        int  viol;
        int  extra;
        logic got;
        exp_q.push_back(exp_txn);
        dma_acknowledge = dack;
        dma_address = a;
        dma_data_in = d;
        dma_memory_read = rd;
        dma_memory_write = wr;
        viol = 0;
        extra = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (dma_ready !== 1'b0) viol++;
            if (mem_m.access && mem_m.ack) got = 1'b1;
            page_sel = pw_sel;
            page_data = pw_val;
            page_write = pw && (i == 1);
        end
        page_write = 1'b0;
        check({name, "_ack_seen"}, 64'(got), 64'd1);
        check({name, "_ready_low"}, 64'(viol), 64'd0);
        @(negedge clock);
        check({name, "_ready_high"}, 64'(dma_ready), 64'd1);
        if (mem_m.access) extra++;
        for (int i = 0; i < hold_after; i++) begin
            @(negedge clock);
            if (mem_m.access) extra++;
        end
        check({name, "_no_retrigger"}, 64'(extra), 64'd0);
        tick();
        dma_memory_read = 1'b0;
        dma_memory_write = 1'b0;
        tick();
        check({name, "_back_grant"}, 64'(arb_state), 64'(GRANT));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          cyc;
        int          stall;
        logic [15:0] rd;
        logic [3:0]  ha;
        logic [3:0]  ak;

        reset = 1'b1;
        hold_request = 1'b0;
        dma_address = 16'h0;
        dma_acknowledge = 4'h0;
        dma_memory_read = 1'b0;
        dma_memory_write = 1'b0;
        dma_data_in = 8'h0;
        page_write = 1'b0;
        page_sel = 2'd0;
        page_data = 4'h0;
        cpu_m.addr = '0;
        cpu_m.data_out = '0;
        cpu_m.access = 1'b0;
        cpu_m.wr_en = 1'b0;
        cpu_m.bytesel = 2'b00;
        repeat (3) tick();
        reset = 1'b0;

        @(negedge clock);
        check("rst_hold_ack", 64'(hold_acknowledge), 64'd0);
        check("rst_dma_ready", 64'(dma_ready), 64'd1);
        check("rst_dma_data", 64'(dma_data_out), 64'd0);
        check("rst_mem_access", 64'(mem_m.access), 64'd0);
        check("rst_cpu_ack", 64'(cpu_m.ack), 64'd0);
        check("rst_state", 64'(arb_state), 64'(IDLE));
        tick();

        // CPU traffic with no DMA: memory port mirrors the CPU port.
        mem_lat = 2;
        mem_rdata = 16'h1234;
        cpu_xfer(19'h12345, 1'b0, 2'b11, 16'h0, cyc, rd);
        check("cpu_rd_latency", 64'(cyc), 64'd2);
        check("cpu_rd_data", 64'(rd), 64'h1234);
        check("cpu_rd_no_hold", 64'(hold_acknowledge), 64'd0);
        mem_lat = 1;
        cpu_xfer(19'h00ABC, 1'b1, 2'b01, 16'h55AA, cyc, rd);
        check("cpu_wr_latency", 64'(cyc), 64'd1);

        // Hold arrives with a CPU access in flight: grant waits for its ack.
        mem_lat = 3;
        mem_rdata = 16'h0BAD;
        exp_q.push_back({19'h0F0F0, 1'b0, 2'b11, 16'h0});
        cpu_m.addr = 19'h0F0F0;
        cpu_m.wr_en = 1'b0;
        cpu_m.bytesel = 2'b11;
        cpu_m.access = 1'b1;
        hold_request = 1'b1;
        ha = '0;
        ak = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ha[i] = hold_acknowledge;
            ak[i] = cpu_m.ack;
        end
        tick();
        cpu_m.access = 1'b0;
        check("drain_hold_ack", 64'(ha), 64'b1000);
        check("drain_cpu_ack", 64'(ak), 64'b0100);

        // New CPU request while the DMA owns the bus is stalled.
        mem_lat = 2;
        exp_q.push_back({19'h11111, 1'b1, 2'b11, 16'h1111});
        cpu_m.addr = 19'h11111;
        cpu_m.wr_en = 1'b1;
        cpu_m.bytesel = 2'b11;
        cpu_m.data_out = 16'h1111;
        cpu_m.access = 1'b1;
        stall = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (mem_m.access || cpu_m.ack) stall++;
        end
        check("stall_cpu_blocked", 64'(stall), 64'd0);
        tick();
        hold_request = 1'b0;
        @(negedge clock);
        check("hold_ack_last_grant", 64'(hold_acknowledge), 64'd1);
        @(negedge clock);
        check("hold_ack_drop", 64'(hold_acknowledge), 64'd0);
        check("stall_release_pass", 64'(mem_m.access), 64'd1);
        wait_cpu_ack(cyc);
        check("stall_release_lat", 64'(cyc), 64'd1);
        tick();
        cpu_m.access = 1'b0;
        cpu_m.wr_en = 1'b0;

        // Hold with the CPU idle: acknowledged one cycle later.
        page_wr(2'd2, 4'hA);
        hold_request = 1'b1;
        @(negedge clock);
        check("hold_ack_cycle0", 64'(hold_acknowledge), 64'd0);
        @(negedge clock);
        check("hold_ack_cycle1", 64'(hold_acknowledge), 64'd1);
        tick();

        mem_lat = 3;
        dma_xfer("memw_page2", 4'b0100, 16'h1235, 1'b0, 1'b1, 8'h5C,
                 {19'h5091A, 1'b1, 2'b10, 16'h5C5C}, 0, 1'b0, 2'd0, 4'h0);

        mem_lat = 2;
        mem_rdata = 16'hBEEF;
        dma_xfer("memr_even", 4'b0001, 16'h0000, 1'b1, 1'b0, 8'h00,
                 {19'h00000, 1'b0, 2'b01, 16'h0}, 4, 1'b0, 2'd0, 4'h0);
        check("memr_even_byte", 64'(dma_data_out), 64'hEF);
        dma_xfer("memr_odd", 4'b0001, 16'h0001, 1'b1, 1'b0, 8'h00,
                 {19'h00000, 1'b0, 2'b10, 16'h0}, 0, 1'b0, 2'd0, 4'h0);
        check("memr_odd_byte", 64'(dma_data_out), 64'hBE);

        mem_rdata = 16'h7733;
        dma_xfer("both_strobes", 4'b1000, 16'h4000, 1'b1, 1'b1, 8'hAA,
                 {19'h02000, 1'b0, 2'b01, 16'h0}, 0, 1'b0, 2'd0, 4'h0);
        check("both_strobes_byte", 64'(dma_data_out), 64'h33);

        page_wr(2'd0, 4'h3);
        dma_xfer("no_dack_wrap", 4'b0000, 16'hFFFF, 1'b0, 1'b1, 8'h81,
                 {19'h1FFFF, 1'b1, 2'b10, 16'h8181}, 0, 1'b0, 2'd0, 4'h0);

        // A page write during XFER lands on the following transfer only.
        page_wr(2'd1, 4'h5);
        mem_lat = 3;
        mem_rdata = 16'h1234;
        dma_xfer("pw_mid_old", 4'b0010, 16'h0010, 1'b1, 1'b0, 8'h00,
                 {19'h28008, 1'b0, 2'b01, 16'h0}, 0, 1'b1, 2'd1, 4'h6);
        dma_xfer("pw_mid_new", 4'b0010, 16'h0010, 1'b1, 1'b0, 8'h00,
                 {19'h30008, 1'b0, 2'b01, 16'h0}, 0, 1'b0, 2'd0, 4'h0);
        check("pw_mid_byte", 64'(dma_data_out), 64'h34);

        // Reset in the middle of a transfer.
        mem_lat = 10;
        dma_acknowledge = 4'b0001;
        dma_address = 16'h0000;
        dma_memory_read = 1'b1;
        repeat (3) tick();
        check("pre_reset_xfer", 64'(arb_state), 64'(XFER));
        reset = 1'b1;
        hold_request = 1'b0;
        tick();
        check("mid_rst_hold_ack", 64'(hold_acknowledge), 64'd0);
        check("mid_rst_mem_access", 64'(mem_m.access), 64'd0);
        check("mid_rst_dma_ready", 64'(dma_ready), 64'd1);
        check("mid_rst_dma_data", 64'(dma_data_out), 64'd0);
        check("mid_rst_state", 64'(arb_state), 64'(IDLE));
        reset = 1'b0;
        dma_memory_read = 1'b0;
        tick();

        hold_request = 1'b1;
        tick();
        mem_lat = 2;
        mem_rdata = 16'hCAFE;
        dma_xfer("rst_page2", 4'b0100, 16'h1235, 1'b1, 1'b0, 8'h00,
                 {19'h0091A, 1'b0, 2'b10, 16'h0}, 0, 1'b0, 2'd0, 4'h0);
        check("rst_page2_byte", 64'(dma_data_out), 64'hCA);
        dma_xfer("rst_page1", 4'b0010, 16'h0010, 1'b1, 1'b0, 8'h00,
                 {19'h00008, 1'b0, 2'b01, 16'h0}, 0, 1'b0, 2'd0, 4'h0);
        check("rst_page1_byte", 64'(dma_data_out), 64'hFE);

        hold_request = 1'b0;
        tick();
        tick();
        check("final_hold_ack", 64'(hold_acknowledge), 64'd0);
        check("final_state", 64'(arb_state), 64'(IDLE));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
